// File: rtl/match_feeder.sv
// Keypoint FIFO and frame-boundary sequencer feeding the matcher's
// flag/next handshake; holds next-frame keypoints until the matcher acks.
module match_feeder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_frame_end,
    input  logic [9:0]        i_coor_x,
    input  logic [9:0]        i_coor_y,
    input  logic [7:0]        i_score,
    input  logic [255:0]      i_descriptor,
    output logic              o_ready,
    output logic              o_overflow,
    output logic [ADDR_W:0]   o_count,
    output logic              o_flag,
    output logic [9:0]        o_coor_x,
    output logic [9:0]        o_coor_y,
    output logic [7:0]        o_score,
    output logic [255:0]      o_descriptor,
    input  logic              i_next,
    output logic              o_frame_next,
    input  logic              i_end
);

    localparam int ENTRY_W = 286;

    typedef enum logic {
        FEED = 1'b0,
        FEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ENTRY_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;

    logic                w_wr_req;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [ENTRY_W-1:0]  w_wdata;
    logic [ENTRY_W-1:0]  w_head;
    logic                w_head_last;
    logic                w_head_feat;
    logic                w_show;

    // Count never exceeds DEPTH (a power of two), so its MSB marks full.
    assign w_full   = r_count[ADDR_W];
    assign w_empty  = (r_count == '0);
    assign w_wr_req = i_valid | i_frame_end;
    assign w_push   = w_wr_req & ~w_full;

    always_comb begin
        w_wdata = '0;
        if (i_valid) begin
            w_wdata = {i_frame_end, 1'b1, i_coor_x, i_coor_y,
                       i_score, i_descriptor};
        end else begin
            w_wdata[ENTRY_W-1] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_last = w_head[285];
    assign w_head_feat = w_head[284];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= FEED;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{ADDR_W{1'b0}}, w_push}
                               - {{ADDR_W{1'b0}}, w_pop};
            if (w_wr_req && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Flag and frame_next are mutually exclusive by construction of the FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_show       = 1'b0;
        o_frame_next = 1'b0;
        unique case (r_state)
            FEED: begin
                if (!w_empty) begin
                    if (w_head_feat) begin
                        w_show = 1'b1;
                        if (i_next) begin
                            w_pop = 1'b1;
                            if (w_head_last) begin
                                w_state_nxt = FEND;
                            end
                        end
                    end else begin
                        w_pop       = 1'b1;
                        w_state_nxt = FEND;
                    end
                end
            end
            FEND: begin
                o_frame_next = 1'b1;
                if (i_end) begin
                    w_state_nxt = FEED;
                end
            end
            default: begin
                w_state_nxt = FEED;
            end
        endcase
    end

    assign o_flag       = w_show;
    assign o_coor_x     = w_show ? w_head[283:274] : '0;
    assign o_coor_y     = w_show ? w_head[273:264] : '0;
    assign o_score      = w_show ? w_head[263:256] : '0;
    assign o_descriptor = w_show ? w_head[255:0]   : '0;
    assign o_ready      = ~w_full;
    assign o_overflow   = r_overflow;
    assign o_count      = r_count;

endmodule
